// File: rtl/fifo_pkg.sv
// Shared mode type, sizing helpers and elaboration-time parameter checks
// for the parametrised synchronous FIFO.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Expands to a generate block that raises an elaboration error when cond is false.
`define FIFO_STATIC_ASSERT(label, cond) \
    if (!(cond)) begin : label \
        $error("fifo_sync_param: illegal parameter combination"); \
    end

package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy needs one bit more than the pointers so that DEPTH itself fits.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`endif

// File: rtl/fifo_if.sv
// Producer/consumer port bundle of the FIFO; the bench clock travels with it.
interface fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic clock
);
    import fifo_pkg::*;

    localparam int CW = count_width(DEPTH);

    // wr/rd are requests, not handshakes: a request is accepted in the cycle it
    // is high only if full (for wr) / empty (for rd) is low in that same cycle;
    // a rejected request is dropped and reported one cycle later on
    // overflow/underflow. The requester never waits for an acknowledge.
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        input  clock,
        output wr, rd, data_in,
        input  data_out, empty, full, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr, rd, data_in,
        output data_out, empty, full, almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Storage array of the FIFO: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately not reset; the pointers define what is valid.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, error
// pulses and a selectable registered or first-word-fall-through read port.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic   clock,
    input logic   rst,
    fifo_if.slave bus
);
    import fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] L_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] L_ONE   = CW'(1);
    localparam logic [AW-1:0] L_PINC  = AW'(1);

    `FIFO_STATIC_ASSERT(g_chk_width, WIDTH >= 1)
    `FIFO_STATIC_ASSERT(g_chk_depth, is_pow2(DEPTH))
    `FIFO_STATIC_ASSERT(g_chk_af, (AF_LEVEL >= 1) && (AF_LEVEL <= DEPTH))
    `FIFO_STATIC_ASSERT(g_chk_ae, (AE_LEVEL >= 0) && (AE_LEVEL <= DEPTH - 1))
    `FIFO_STATIC_ASSERT(g_chk_mode, (FWFT == 0) || (FWFT == 1))

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_data_out;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_wr_rej;
    logic             w_rd_rej;
    logic             w_mem_we;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_mem_rdata;

    // Acceptance uses the registered flags, so a simultaneous read never frees
    // a slot for a write in the same cycle (no write-through when full).
    always_comb begin
        w_wr_acc    = bus.wr && !r_full;
        w_rd_acc    = bus.rd && !r_empty;
        w_wr_rej    = bus.wr && r_full;
        w_rd_rej    = bus.rd && r_empty;
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + L_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - L_ONE;
        end
    end

    assign w_mem_we = w_wr_acc && !rst;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clock (clock),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Flags are computed from the next-state count so they never lag count.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_data_out     <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + L_PINC;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + L_PINC;
                r_data_out <= w_mem_rdata;
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == L_DEPTH);
            r_almost_full  <= (w_count_nxt >= L_AF);
            r_almost_empty <= (w_count_nxt <= L_AE);
            r_overflow     <= w_wr_rej;
            r_underflow    <= w_rd_rej;
        end
    end

    // In FWFT mode the head word is shown directly; it is forced to zero while
    // empty so the port never exposes stale memory contents.
    assign bus.data_out     = (MODE == fifo_pkg::FWFT) ? (r_empty ? '0 : w_mem_rdata)
                                                       : r_data_out;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-read FIFO and an FWFT FIFO (WIDTH=8, DEPTH=16,
// AF=14, AE=2) checked against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_a (.clock(clk));
  fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_b (.clock(clk));

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) dut_a (
    .clock (bus_a.clock),
    .rst   (rst),
    .bus   (bus_a)
  );

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) dut_b (
    .clock (bus_b.clock),
    .rst   (rst),
    .bus   (bus_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // scoreboard state: expected queues and modelled occupancy
  logic [7:0] exp_q[$];
  logic [7:0] exp_qb[$];
  int         sa_cnt;
  int         sb_cnt;
  logic [7:0] a_last;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input int exp_cnt, input logic exp_ovf, input logic exp_unf);
    chk("a_count",        32'(bus_a.count),        32'(exp_cnt));
    chk("a_empty",        32'(bus_a.empty),        32'(exp_cnt == 0));
    chk("a_full",         32'(bus_a.full),         32'(exp_cnt == DEPTH));
    chk("a_almost_full",  32'(bus_a.almost_full),  32'(exp_cnt >= AF));
    chk("a_almost_empty", 32'(bus_a.almost_empty), 32'(exp_cnt <= AE));
    chk("a_overflow",     32'(bus_a.overflow),     32'(exp_ovf));
    chk("a_underflow",    32'(bus_a.underflow),    32'(exp_unf));
  endtask

  // driver for the standard FIFO with explicit expected count/pulses
  task automatic apply_a(input logic wr, input logic rd, input logic [7:0] din,
                         input int exp_cnt, input logic exp_ovf, input logic exp_unf);
    logic       wacc;
    logic       racc;
    logic [7:0] exp_d;
    exp_d = '0;
    @(negedge clk);
    bus_a.wr      = wr;
    bus_a.rd      = rd;
    bus_a.data_in = din;
    wacc = wr && (sa_cnt != DEPTH);
    racc = rd && (sa_cnt != 0);
    if (racc) begin
      if (exp_q.size() > 0) exp_d = exp_q.pop_front();
    end
    if (wacc) exp_q.push_back(din);
    @(posedge clk);
    #1;
    bus_a.wr = 1'b0;
    bus_a.rd = 1'b0;
    check_a(exp_cnt, exp_ovf, exp_unf);
    if (racc) begin
      chk("a_data", 32'(bus_a.data_out), 32'(exp_d));
      a_last = exp_d;
    end else begin
      chk("a_data_hold", 32'(bus_a.data_out), 32'(a_last));
    end
    sa_cnt = exp_cnt;
  endtask

  // driver for the standard FIFO with expectations from the reference model
  task automatic run_a(input logic wr, input logic rd, input logic [7:0] din);
    logic wacc;
    logic racc;
    wacc = wr && (sa_cnt != DEPTH);
    racc = rd && (sa_cnt != 0);
    apply_a(wr, rd, din, sa_cnt + int'(wacc) - int'(racc), wr && !wacc, rd && !racc);
  endtask

  // driver for the FWFT FIFO: head of the expected queue must be on data_out
  task automatic run_b(input logic wr, input logic rd, input logic [7:0] din);
    logic wacc;
    logic racc;
    logic [7:0] dummy;
    @(negedge clk);
    bus_b.wr      = wr;
    bus_b.rd      = rd;
    bus_b.data_in = din;
    wacc = wr && (sb_cnt != DEPTH);
    racc = rd && (sb_cnt != 0);
    if (racc && exp_qb.size() > 0) dummy = exp_qb.pop_front();
    if (wacc) exp_qb.push_back(din);
    sb_cnt = sb_cnt + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    bus_b.wr = 1'b0;
    bus_b.rd = 1'b0;
    chk("b_count",     32'(bus_b.count),     32'(sb_cnt));
    chk("b_empty",     32'(bus_b.empty),     32'(sb_cnt == 0));
    chk("b_full",      32'(bus_b.full),      32'(sb_cnt == DEPTH));
    chk("b_overflow",  32'(bus_b.overflow),  32'(wr && !wacc));
    chk("b_underflow", 32'(bus_b.underflow), 32'(rd && !racc));
    if (exp_qb.size() > 0) chk("b_data", 32'(bus_b.data_out), 32'(exp_qb[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    sa_cnt = 0;
    sb_cnt = 0;
    a_last = '0;
    bus_a.wr = 1'b0; bus_a.rd = 1'b0; bus_a.data_in = '0;
    bus_b.wr = 1'b0; bus_b.rd = 1'b0; bus_b.data_in = '0;
    rst = 1'b1;

    // table: underflow corners, write+read while empty, mixed traffic
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_a(0, 1'b0, 1'b0);
    chk("a_reset_data", 32'(bus_a.data_out), 32'h0);
    chk("b_reset_count", 32'(bus_b.count), 32'h0);
    chk("b_reset_empty", 32'(bus_b.empty), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_a(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_unf);
    end

    // fill 0x00..0x0F and drain in order
    for (int i = 0; i < DEPTH; i++) run_a(1'b1, 1'b0, 8'(i));
    chk("a_full_after_16", 32'(bus_a.full), 32'h1);
    for (int i = 0; i < DEPTH; i++) run_a(1'b0, 1'b1, 8'h00);
    chk("a_empty_after_16", 32'(bus_a.empty), 32'h1);

    // full corner: lone writes overflow back-to-back, then write+read with 0xAA
    for (int i = 0; i < DEPTH; i++) run_a(1'b1, 1'b0, 8'(i));
    run_a(1'b1, 1'b0, 8'hEE);
    run_a(1'b1, 1'b0, 8'hEE);
    apply_a(1'b1, 1'b1, 8'hAA, 15, 1'b1, 1'b0);
    run_a(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) run_a(1'b0, 1'b1, 8'h00);
    run_a(1'b0, 1'b1, 8'h00);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      run_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    while (sa_cnt != 0) run_a(1'b0, 1'b1, 8'h00);

    // reset mid-operation with count 9 and both requests high
    for (int i = 0; i < 9; i++) run_a(1'b1, 1'b0, 8'(8'h90 + i));
    chk("a_count_before_rst", 32'(bus_a.count), 32'd9);
    @(negedge clk);
    rst = 1'b1;
    bus_a.wr = 1'b1; bus_a.rd = 1'b1; bus_a.data_in = 8'h77;
    @(posedge clk);
    #1;
    check_a(0, 1'b0, 1'b0);
    chk("a_rst_data", 32'(bus_a.data_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.wr = 1'b0; bus_a.rd = 1'b0;
    exp_q.delete();
    sa_cnt = 0;
    a_last = '0;
    exp_qb.delete();
    sb_cnt = 0;
    run_a(1'b1, 1'b0, 8'h5A);
    run_a(1'b0, 1'b1, 8'h00);
    run_a(1'b0, 1'b0, 8'h00);

    // FWFT: 0x3C visible the cycle after the write without any read
    run_b(1'b1, 1'b0, 8'h3C);
    chk("b_fwft_3c", 32'(bus_b.data_out), 32'h3C);
    for (int i = 0; i < 3; i++) run_b(1'b1, 1'b0, 8'(8'h41 + i));
    for (int i = 0; i < 40; i++) run_b(1'b1, 1'b1, 8'(8'h50 + i));
    chk("b_count_const", 32'(bus_b.count), 32'd4);
    for (int i = 0; i < 5; i++) run_b(1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
